// File: rtl/mem_line_responder_pkg.sv
// Shared types and configuration constants for the line-wide memory responder.
package mem_line_responder_pkg;

  localparam int unsigned MLR_LINE_SIZE      = 64;
  localparam int unsigned MLR_LINE_BITS      = 8 * MLR_LINE_SIZE;
  localparam int unsigned MLR_ADDR_WIDTH     = 26;
  localparam int unsigned MLR_TAG_WIDTH      = 8;
  localparam int unsigned MLR_MEM_LINES      = 256;
  localparam int unsigned MLR_LATENCY        = 4;
  localparam int unsigned MLR_RSP_QUEUE_SIZE = 8;
  localparam int unsigned MLR_PERF_CTR_BITS  = 44;

  localparam bit MLR_LATENCY_OK = (MLR_LATENCY >= 1);
  localparam bit MLR_QUEUE_OK   = (MLR_RSP_QUEUE_SIZE >= MLR_LATENCY);

  typedef struct packed {
    logic                      rw;
    logic [MLR_ADDR_WIDTH-1:0] addr;
    logic [MLR_LINE_SIZE-1:0]  byteen;
    logic [MLR_LINE_BITS-1:0]  data;
    logic [MLR_TAG_WIDTH-1:0]  tag;
  } mem_req_t;

  typedef struct packed {
    logic [MLR_LINE_BITS-1:0] data;
    logic [MLR_TAG_WIDTH-1:0] tag;
  } mem_rsp_t;

  // Every read needs a reserved FIFO slot for the whole time it is in flight.
  function automatic bit cfg_ok(input int unsigned latency, input int unsigned queue_size);
    return (latency >= 1) && (queue_size >= latency);
  endfunction

endpackage

// File: rtl/mem_line_rsp_fifo.sv
// First-word-fall-through response FIFO; pointers reset, storage does not.
module mem_line_rsp_fifo
  import mem_line_responder_pkg::*;
#(
  parameter int unsigned DEPTH = MLR_RSP_QUEUE_SIZE
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     push,
  input  mem_rsp_t wdata,
  input  logic     pop,
  output mem_rsp_t rdata,
  output logic     empty,
  output logic     full
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  mem_rsp_t            mem_q [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                push_ok_c, pop_ok_c;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign push_ok_c = push && !full;
  assign pop_ok_c  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok_c) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop_ok_c)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push_ok_c, pop_ok_c})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok_c) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CNT_W'(DEPTH));

endmodule

// File: rtl/mem_line_responder.sv
// Memory-side slave for the line request/response bus: byte-enabled line store,
// fixed-latency in-order read responses, credit-based request flow control.
module mem_line_responder
  import mem_line_responder_pkg::*;
#(
  parameter int unsigned LINE_SIZE      = MLR_LINE_SIZE,
  parameter int unsigned ADDR_WIDTH     = MLR_ADDR_WIDTH,
  parameter int unsigned TAG_WIDTH      = MLR_TAG_WIDTH,
  parameter int unsigned MEM_LINES      = MLR_MEM_LINES,
  parameter int unsigned LATENCY        = MLR_LATENCY,
  parameter int unsigned RSP_QUEUE_SIZE = MLR_RSP_QUEUE_SIZE,
  parameter int unsigned PERF_CTR_BITS  = MLR_PERF_CTR_BITS
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     mem_req_valid,
  input  logic                     mem_req_rw,
  input  logic [ADDR_WIDTH-1:0]    mem_req_addr,
  input  logic [LINE_SIZE-1:0]     mem_req_byteen,
  input  logic [8*LINE_SIZE-1:0]   mem_req_data,
  input  logic [TAG_WIDTH-1:0]     mem_req_tag,
  output logic                     mem_req_ready,
  output logic                     mem_rsp_valid,
  output logic [8*LINE_SIZE-1:0]   mem_rsp_data,
  output logic [TAG_WIDTH-1:0]     mem_rsp_tag,
  input  logic                     mem_rsp_ready,
  output logic [PERF_CTR_BITS-1:0] perf_reads,
  output logic [PERF_CTR_BITS-1:0] perf_writes,
  output logic [PERF_CTR_BITS-1:0] perf_rsp_stalls
);

  localparam int unsigned LINE_BITS = 8 * LINE_SIZE;
  localparam int unsigned IDX_W     = (MEM_LINES > 1) ? $clog2(MEM_LINES) : 1;
  localparam int unsigned CNT_W     = $clog2(RSP_QUEUE_SIZE + 1);
  localparam int unsigned NSTG      = (LATENCY > 1) ? LATENCY - 1 : 1;

  // Bus payload structs are fixed by the package, so the bus widths must match it.
  if (!cfg_ok(LATENCY, RSP_QUEUE_SIZE) || !MLR_LATENCY_OK || !MLR_QUEUE_OK ||
      (LINE_SIZE != MLR_LINE_SIZE) || (ADDR_WIDTH != MLR_ADDR_WIDTH) ||
      (TAG_WIDTH != MLR_TAG_WIDTH)) begin : g_bad_cfg
    $error("mem_line_responder: unsupported parameter set");
  end

  mem_req_t                 req_c;
  mem_rsp_t                 rd_rsp_c;
  mem_rsp_t                 fifo_wdata_c;
  mem_rsp_t                 fifo_rdata_c;
  logic                     fifo_push_c;
  logic                     fifo_empty_c;
  logic                     fifo_full_c;
  logic [IDX_W-1:0]         idx_c;
  logic                     req_fire_c, rd_fire_c, wr_fire_c, rsp_fire_c, stall_c;
  logic                     unused_addr_bits;

  logic [LINE_BITS-1:0]     mem_q [MEM_LINES];
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     ready_q, ready_d;
  logic [PERF_CTR_BITS-1:0] perf_reads_q, perf_reads_d;
  logic [PERF_CTR_BITS-1:0] perf_writes_q, perf_writes_d;
  logic [PERF_CTR_BITS-1:0] perf_stalls_q, perf_stalls_d;

  always_comb begin
    req_c        = '0;
    req_c.rw     = mem_req_rw;
    req_c.addr   = mem_req_addr;
    req_c.byteen = mem_req_byteen;
    req_c.data   = mem_req_data;
    req_c.tag    = mem_req_tag;
  end

  // Upper line-address bits are don't-care: the store aliases modulo MEM_LINES.
  assign idx_c            = req_c.addr[IDX_W-1:0];
  assign unused_addr_bits = ^req_c.addr;

  assign req_fire_c  = mem_req_valid && ready_q;
  assign rd_fire_c   = req_fire_c && !req_c.rw;
  assign wr_fire_c   = req_fire_c && req_c.rw;
  assign rsp_fire_c  = mem_rsp_valid && mem_rsp_ready;
  assign stall_c     = mem_rsp_valid && !mem_rsp_ready;

  always_ff @(posedge clk) begin
    if (wr_fire_c) begin
      for (int unsigned b = 0; b < LINE_SIZE; b++) begin
        if (req_c.byteen[b]) mem_q[idx_c][8*b +: 8] <= req_c.data[8*b +: 8];
      end
    end
  end

  // Read sees every write accepted in an earlier cycle.
  always_comb begin
    rd_rsp_c      = '0;
    rd_rsp_c.data = mem_q[idx_c];
    rd_rsp_c.tag  = req_c.tag;
  end

  if (LATENCY == 1) begin : g_no_pipe
    assign fifo_push_c  = rd_fire_c;
    assign fifo_wdata_c = rd_rsp_c;
  end else begin : g_pipe
    logic [NSTG-1:0] vld_q, vld_d;
    mem_rsp_t        dat_q [NSTG];
    mem_rsp_t        dat_d [NSTG];

    always_comb begin
      vld_d[0] = rd_fire_c;
      dat_d[0] = rd_rsp_c;
      for (int unsigned i = 1; i < NSTG; i++) begin
        vld_d[i] = vld_q[i-1];
        dat_d[i] = dat_q[i-1];
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) vld_q <= '0;
      else       vld_q <= vld_d;
    end

    always_ff @(posedge clk) begin
      dat_q <= dat_d;
    end

    assign fifo_push_c  = vld_q[NSTG-1];
    assign fifo_wdata_c = dat_q[NSTG-1];
  end

  mem_line_rsp_fifo #(
    .DEPTH (RSP_QUEUE_SIZE)
  ) u_rsp_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push_c),
    .wdata (fifo_wdata_c),
    .pop   (mem_rsp_ready),
    .rdata (fifo_rdata_c),
    .empty (fifo_empty_c),
    .full  (fifo_full_c)
  );

  // Credits cover pipeline plus FIFO, so a stalled consumer never causes overflow.
  always_comb begin
    cnt_d = cnt_q;
    case ({rd_fire_c, rsp_fire_c})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
    ready_d       = (cnt_d < CNT_W'(RSP_QUEUE_SIZE));
    perf_reads_d  = perf_reads_q + PERF_CTR_BITS'(rd_fire_c);
    perf_writes_d = perf_writes_q + PERF_CTR_BITS'(wr_fire_c);
    perf_stalls_d = perf_stalls_q + PERF_CTR_BITS'(stall_c);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q         <= '0;
      ready_q       <= 1'b1;
      perf_reads_q  <= '0;
      perf_writes_q <= '0;
      perf_stalls_q <= '0;
    end else begin
      cnt_q         <= cnt_d;
      ready_q       <= ready_d;
      perf_reads_q  <= perf_reads_d;
      perf_writes_q <= perf_writes_d;
      perf_stalls_q <= perf_stalls_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (cnt_q <= CNT_W'(RSP_QUEUE_SIZE));
      assert (!(rsp_fire_c && !rd_fire_c && (cnt_q == '0)));
      assert (!(fifo_push_c && fifo_full_c));
    end
  end

  assign mem_req_ready   = ready_q;
  assign mem_rsp_valid   = !fifo_empty_c;
  assign mem_rsp_data    = fifo_rdata_c.data;
  assign mem_rsp_tag     = fifo_rdata_c.tag;
  assign perf_reads      = perf_reads_q;
  assign perf_writes     = perf_writes_q;
  assign perf_rsp_stalls = perf_stalls_q;

endmodule

// File: tb/tb_mem_line_responder.sv
// Self-checking bench for mem_line_responder: vector table plus scoreboarded corner sequences.
module tb_mem_line_responder;

  localparam int unsigned LS  = 64;
  localparam int unsigned LB  = 8 * LS;
  localparam int unsigned AW  = 26;
  localparam int unsigned TW  = 8;
  localparam int unsigned PW  = 44;
  localparam int unsigned LAT = 4;
  localparam int unsigned NV  = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic          mem_req_valid;
  logic          mem_req_rw;
  logic [AW-1:0] mem_req_addr;
  logic [LS-1:0] mem_req_byteen;
  logic [LB-1:0] mem_req_data;
  logic [TW-1:0] mem_req_tag;
  logic          mem_req_ready;
  logic          mem_rsp_valid;
  logic [LB-1:0] mem_rsp_data;
  logic [TW-1:0] mem_rsp_tag;
  logic          mem_rsp_ready;
  logic [PW-1:0] perf_reads;
  logic [PW-1:0] perf_writes;
  logic [PW-1:0] perf_rsp_stalls;

  mem_line_responder dut (
    .clk             (clk),
    .reset           (reset),
    .mem_req_valid   (mem_req_valid),
    .mem_req_rw      (mem_req_rw),
    .mem_req_addr    (mem_req_addr),
    .mem_req_byteen  (mem_req_byteen),
    .mem_req_data    (mem_req_data),
    .mem_req_tag     (mem_req_tag),
    .mem_req_ready   (mem_req_ready),
    .mem_rsp_valid   (mem_rsp_valid),
    .mem_rsp_data    (mem_rsp_data),
    .mem_rsp_tag     (mem_rsp_tag),
    .mem_rsp_ready   (mem_rsp_ready),
    .perf_reads      (perf_reads),
    .perf_writes     (perf_writes),
    .perf_rsp_stalls (perf_rsp_stalls)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [LB-1:0] data;
    logic [TW-1:0] tag;
  } exp_t;

  typedef struct packed {
    logic          rw;
    logic [AW-1:0] addr;
    logic [LS-1:0] be;
    logic [7:0]    wbyte;
    logic [TW-1:0] tag;
    logic [7:0]    exp0;
    logic [7:0]    exp_rest;
  } vec_t;

  exp_t          exp_q[$];
  exp_t          mon_e;
  vec_t          tbl [NV];
  logic [LB-1:0] model_mem [256];
  int            checks = 0;
  int            errors = 0;
  int            stall_obs = 0;
  logic          held = 1'b0;
  logic [LB-1:0] held_data;
  logic [TW-1:0] held_tag;

  function automatic logic [LB-1:0] fill(input logic [7:0] b0, input logic [7:0] rest);
    logic [LB-1:0] r;
    for (int b = 0; b < LS; b++) r[8*b +: 8] = (b == 0) ? b0 : rest;
    return r;
  endfunction

  task automatic check(input string name, input logic [LB-1:0] act, input logic [LB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one request; the expected response is queued only if it gets accepted.
  task automatic send(input logic rw, input logic [AW-1:0] addr, input logic [LS-1:0] be,
                      input logic [7:0] wbyte, input logic [TW-1:0] tag,
                      input bit use_exp, input logic [LB-1:0] exp_line,
                      input int max_wait, output bit acc);
    logic [7:0] idx;
    exp_t       e;
    acc = 1'b0;
    idx = addr[7:0];
    @(negedge clk);
    mem_req_valid  = 1'b1;
    mem_req_rw     = rw;
    mem_req_addr   = addr;
    mem_req_byteen = be;
    mem_req_data   = fill(wbyte, wbyte);
    mem_req_tag    = tag;
    for (int i = 0; i < max_wait; i++) begin
      if (mem_req_ready) begin
        acc = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (acc) begin
      if (rw) begin
        for (int b = 0; b < LS; b++) if (be[b]) model_mem[idx][8*b +: 8] = wbyte;
      end else begin
        e.data = use_exp ? exp_line : model_mem[idx];
        e.tag  = tag;
        exp_q.push_back(e);
      end
      @(posedge clk);
    end
    #1 mem_req_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !mem_rsp_valid) begin
        done = 1'b1;
        break;
      end
    end
    check(name, LB'(done), LB'(1));
  endtask

  // Response monitor: in-order scoreboard, stall stability, stall cycle count.
  always @(negedge clk) begin
    if (reset) begin
      held = 1'b0;
    end else begin
      if (held && mem_rsp_valid) begin
        check("rsp_hold_data", mem_rsp_data, held_data);
        check("rsp_hold_tag", LB'(mem_rsp_tag), LB'(held_tag));
      end
      if (mem_rsp_valid && !mem_rsp_ready) stall_obs++;
      held      = mem_rsp_valid && !mem_rsp_ready;
      held_data = mem_rsp_data;
      held_tag  = mem_rsp_tag;
      if (mem_rsp_valid && mem_rsp_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected: got tag %0h expected no response", mem_rsp_tag);
        end else begin
          mon_e = exp_q.pop_front();
          check("rsp_data", mem_rsp_data, mon_e.data);
          check("rsp_tag", LB'(mem_rsp_tag), LB'(mon_e.tag));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    bit acc;
    int lat;
    int n_acc;
    int nw;
    int nr;
    int bad;

    tbl[0]  = '{1'b1, 26'h10,      {LS{1'b1}},             8'hA5, 8'h00, 8'h00, 8'h00};
    tbl[1]  = '{1'b0, 26'h10,      '0,                     8'h00, 8'h10, 8'hA5, 8'hA5};
    tbl[2]  = '{1'b1, 26'h10,      64'h1,                  8'h77, 8'h00, 8'h00, 8'h00};
    tbl[3]  = '{1'b0, 26'h10,      '0,                     8'h00, 8'h11, 8'h77, 8'hA5};
    tbl[4]  = '{1'b1, 26'h110,     {LS{1'b1}},             8'h3C, 8'h00, 8'h00, 8'h00};
    tbl[5]  = '{1'b0, 26'h010,     '0,                     8'h00, 8'h12, 8'h3C, 8'h3C};
    tbl[6]  = '{1'b1, 26'h20,      {LS{1'b1}},             8'h11, 8'h00, 8'h00, 8'h00};
    tbl[7]  = '{1'b1, 26'h20,      '0,                     8'hFF, 8'h00, 8'h00, 8'h00};
    tbl[8]  = '{1'b0, 26'h3FFFF20, '0,                     8'h00, 8'h13, 8'h11, 8'h11};
    tbl[9]  = '{1'b1, 26'h21,      {LS{1'b1}},             8'h00, 8'h00, 8'h00, 8'h00};
    tbl[10] = '{1'b1, 26'h21,      64'hFFFF_FFFF_FFFF_FFFE, 8'h22, 8'h00, 8'h00, 8'h00};
    tbl[11] = '{1'b0, 26'h21,      '0,                     8'h00, 8'h14, 8'h00, 8'h22};

    reset          = 1'b1;
    mem_req_valid  = 1'b0;
    mem_req_rw     = 1'b0;
    mem_req_addr   = '0;
    mem_req_byteen = '0;
    mem_req_data   = '0;
    mem_req_tag    = '0;
    mem_rsp_ready  = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_rsp_valid", LB'(mem_rsp_valid), LB'(0));
    check("reset_perf_reads", LB'(perf_reads), LB'(0));
    check("reset_perf_writes", LB'(perf_writes), LB'(0));
    check("reset_perf_stalls", LB'(perf_rsp_stalls), LB'(0));
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset", LB'(mem_req_ready), LB'(1));

    // Full-line write then read: fixed latency with an empty FIFO.
    send(1'b1, 26'h10, {LS{1'b1}}, 8'hA5, 8'h00, 1'b0, '0, 50, acc);
    send(1'b0, 26'h10, '0, 8'h00, 8'h03, 1'b1, fill(8'hA5, 8'hA5), 50, acc);
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (mem_rsp_valid) begin
        lat = n;
        break;
      end
    end
    check("read_latency", LB'(lat), LB'(LAT));
    wait_drain("drain_first");
    check("perf_writes_first", LB'(perf_writes), LB'(1));
    check("perf_reads_first", LB'(perf_reads), LB'(1));

    // Vector table: byte enables, no-op write, address wrap, back-to-back traffic.
    nw = 0;
    nr = 0;
    for (int i = 0; i < NV; i++) begin
      send(tbl[i].rw, tbl[i].addr, tbl[i].be, tbl[i].wbyte, tbl[i].tag,
           !tbl[i].rw, fill(tbl[i].exp0, tbl[i].exp_rest), 50, acc);
      check("tbl_accept", LB'(acc), LB'(1));
      if (tbl[i].rw) nw++;
      else           nr++;
    end
    wait_drain("drain_table");
    check("perf_writes_table", LB'(perf_writes), LB'(1 + nw));
    check("perf_reads_table", LB'(perf_reads), LB'(1 + nr));

    // Stalled consumer: ten reads offered, only the credit limit gets in.
    @(posedge clk);
    #1 mem_rsp_ready = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 10; i++) begin
      send(1'b0, 26'h21, '0, 8'h00, TW'(i), 1'b0, '0, (i < 8) ? 50 : 3, acc);
      if (acc) n_acc++;
    end
    check("stall_accepted", LB'(n_acc), LB'(8));
    @(negedge clk);
    check("ready_low_full", LB'(mem_req_ready), LB'(0));
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1 check("perf_stalls_mid", LB'(perf_rsp_stalls), LB'(stall_obs));

    // One dequeue frees a credit; then dequeue and read in the same cycle.
    mem_rsp_ready = 1'b1;
    @(posedge clk);
    #1 mem_rsp_ready = 1'b0;
    @(negedge clk);
    check("ready_after_pop", LB'(mem_req_ready), LB'(1));
    @(posedge clk);
    #1 mem_rsp_ready = 1'b1;
    send(1'b0, 26'h21, '0, 8'h00, 8'h08, 1'b0, '0, 50, acc);
    mem_rsp_ready = 1'b0;
    check("swap_accept", LB'(acc), LB'(1));
    @(negedge clk);
    check("ready_after_swap", LB'(mem_req_ready), LB'(1));
    send(1'b0, 26'h21, '0, 8'h00, 8'h09, 1'b0, '0, 50, acc);
    check("refill_accept", LB'(acc), LB'(1));
    @(negedge clk);
    check("ready_low_refill", LB'(mem_req_ready), LB'(0));
    @(posedge clk);
    #1 mem_rsp_ready = 1'b1;
    wait_drain("drain_stall");
    @(posedge clk);
    #1 check("perf_stalls_end", LB'(perf_rsp_stalls), LB'(stall_obs));

    // Asynchronous reset with reads in flight discards them.
    mem_rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send(1'b0, 26'h10, '0, 8'h00, TW'(8'h30 + i), 1'b0, '0, 50, acc);
    end
    repeat (4) @(negedge clk);
    check("pre_reset_valid", LB'(mem_rsp_valid), LB'(1));
    #2 reset = 1'b1;
    #1;
    check("reset_async_valid", LB'(mem_rsp_valid), LB'(0));
    check("reset_async_reads", LB'(perf_reads), LB'(0));
    check("reset_async_stalls", LB'(perf_rsp_stalls), LB'(0));
    exp_q.delete();
    stall_obs = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1 mem_rsp_ready = 1'b1;
    bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (mem_rsp_valid) bad++;
    end
    check("no_stale_rsp", LB'(bad), LB'(0));
    check("ready_post_reset", LB'(mem_req_ready), LB'(1));
    check("perf_reads_post", LB'(perf_reads), LB'(0));
    check("perf_writes_post", LB'(perf_writes), LB'(0));
    check("perf_stalls_post", LB'(perf_rsp_stalls), LB'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
